// File: rtl/ppu_vram_arb.sv
// ppu_vram_arb: owner and sequencer of the single-port PPU VRAM bus.
// Shares the bus between the background fetcher, the sprite fetcher and CPU
// PPUDATA accesses. Rendering fetchers own their dot slots; the CPU goes
// through a small IDLE/ACCESS/CAPTURE/DONE handshake FSM.
// Optional feature macro: PPU_ARB_IDLE_SLOT_EN (CPU window at dots 336..338).
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   x_idx, scanline       current dot / line
//   render_en             PPUMASK rendering enable
//   bg_addr, spr_addr     fetcher addresses (bits [13:0] used)
//   cpu_req/we/addr/wdata CPU request (level, held until cpu_ack)
//   mem_rdata             VRAM data, valid the cycle after mem_addr
//   mem_addr/we/wdata     VRAM bus
//   grant_bg/spr/cpu      one-hot bus owner
//   cpu_ack, cpu_rdata    completion pulse and read result
//   cpu_wait              saturating count of cycles the request has waited
module ppu_vram_arb #(
    parameter int VIS_LINES = 240,
    parameter int PRE_LINE  = 261,
    parameter int WAIT_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        x_idx,
    input  logic [9:0]        scanline,
    input  logic              render_en,
    input  logic [15:0]       bg_addr,
    input  logic [15:0]       spr_addr,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [13:0]       cpu_addr,
    input  logic [7:0]        cpu_wdata,
    input  logic [7:0]        mem_rdata,
    output logic [13:0]       mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    output logic              grant_bg,
    output logic              grant_spr,
    output logic              grant_cpu,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    output logic [WAIT_W-1:0] cpu_wait
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACCESS  = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [9:0] VIS_L = 10'(VIS_LINES);
    localparam logic [9:0] PRE_L = 10'(PRE_LINE);

    logic [1:0]        state;
    logic [13:0]       lat_addr;
    logic              lat_we;
    logic [7:0]        lat_wdata;
    logic [7:0]        rdata_q;
    logic [WAIT_W-1:0] wait_q;

    logic render_line;
    logic spr_slot;
    logic cpu_slot;
    logic own_cpu;
    logic accept;
    logic unused_ok;

    assign unused_ok = ^{bg_addr[15:14], spr_addr[15:14]};

    assign render_line = render_en &&
                         (scanline < VIS_L || scanline == PRE_L);

    assign spr_slot = render_line &&
                      x_idx >= 10'd256 && x_idx <= 10'd319;

`ifdef PPU_ARB_IDLE_SLOT_EN
    assign cpu_slot = !render_line ||
                      (x_idx >= 10'd336 && x_idx <= 10'd338);
`else
    assign cpu_slot = !render_line;
`endif

    // A closed window in the ACCESS cycle leaves the fetcher on the bus.
    // Reset also suppresses the CPU so a pending write never lands.
    assign own_cpu = !reset && state == S_ACCESS && cpu_slot;

    assign grant_cpu = own_cpu;
    assign grant_spr = !own_cpu && spr_slot;
    assign grant_bg  = !own_cpu && !spr_slot;

    always_comb begin
        mem_addr = bg_addr[13:0];
        unique case (1'b1)
            grant_cpu: mem_addr = lat_addr;
            grant_spr: mem_addr = spr_addr[13:0];
            grant_bg:  mem_addr = bg_addr[13:0];
        endcase
    end

    assign mem_we    = own_cpu && lat_we;
    assign mem_wdata = own_cpu ? lat_wdata : 8'h00;

    assign cpu_ack = !reset &&
                     (state == S_CAPTURE || state == S_DONE);

    // Read data is visible in the ack cycle straight from memory,
    // then held in rdata_q until the next read completes.
    assign cpu_rdata = (!reset && state == S_CAPTURE) ? mem_rdata : rdata_q;

    assign accept = state == S_IDLE && cpu_req && cpu_slot && !cpu_ack;

    assign cpu_wait = wait_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            lat_addr  <= '0;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
            rdata_q   <= '0;
            wait_q    <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        lat_addr  <= cpu_addr;
                        lat_we    <= cpu_we;
                        lat_wdata <= cpu_wdata;
                        state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (!cpu_slot)
                        state <= S_IDLE;
                    else if (lat_we)
                        state <= S_DONE;
                    else
                        state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    rdata_q <= mem_rdata;
                    state   <= S_IDLE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
            endcase

            if (!cpu_req || accept)
                wait_q <= '0;
            else if (state == S_IDLE && wait_q != '1)
                wait_q <= wait_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_ppu_vram_arb.sv
// tb_ppu_vram_arb: directed self-checking bench for ppu_vram_arb.
// Covers reset, CPU write/read, render sweep, window abort, idle slot, reset.
module tb_ppu_vram_arb;

`ifdef PPU_ARB_IDLE_SLOT_EN
    localparam bit IDLE_EN = 1'b1;
`else
    localparam bit IDLE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  x_idx;
    logic [9:0]  scanline;
    logic        render_en;
    logic [15:0] bg_addr;
    logic [15:0] spr_addr;
    logic        cpu_req;
    logic        cpu_we;
    logic [13:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic [13:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic        grant_bg;
    logic        grant_spr;
    logic        grant_cpu;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [7:0]  cpu_wait;

    int npass = 0;
    int ntot  = 0;

    ppu_vram_arb dut (
        .clk       (clk),
        .reset     (reset),
        .x_idx     (x_idx),
        .scanline  (scanline),
        .render_en (render_en),
        .bg_addr   (bg_addr),
        .spr_addr  (spr_addr),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .grant_bg  (grant_bg),
        .grant_spr (grant_spr),
        .grant_cpu (grant_cpu),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .cpu_wait  (cpu_wait)
    );

    always #5 clk = ~clk;

    // Memory model: 1-cycle synchronous read, data = addr[7:0] ^ 0x7F.
    always @(posedge clk) mem_rdata <= mem_addr[7:0] ^ 8'h7F;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] gvec();
        return {29'd0, grant_bg, grant_spr, grant_cpu};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        render_en = 1'b1;
        scanline  = 10'd10;
        x_idx     = 10'd300;
        bg_addr   = 16'h8400;
        spr_addr  = 16'hF9AB;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 14'h0;
        cpu_wdata = 8'h00;
        #1;
        chk("rst_grant", gvec(), 3'b010);
        chk("rst_addr", mem_addr, 14'h39AB);
        tick();
        chk("rst_wait", cpu_wait, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_ack", cpu_ack, 0);
        chk("rst_we", mem_we, 0);
        reset = 1'b0;

        // CPU write, rendering off
        render_en = 1'b0;
        x_idx     = 10'd0;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 14'h2005;
        cpu_wdata = 8'hA7;
        #1;
        chk("wr_idle_grant", gvec(), 3'b100);
        tick();
        cpu_addr  = 14'h0;
        cpu_wdata = 8'h00;
        #1;
        chk("wr_acc_grant", gvec(), 3'b001);
        chk("wr_acc_we", mem_we, 1);
        chk("wr_acc_addr", mem_addr, 14'h2005);
        chk("wr_acc_data", mem_wdata, 8'hA7);
        chk("wr_acc_ack", cpu_ack, 0);
        tick();
        chk("wr_ack", cpu_ack, 1);
        chk("wr_ack_we", mem_we, 0);
        chk("wr_ack_grant", gvec(), 3'b100);
        cpu_req = 1'b0;
        tick();
        chk("wr_post_ack", cpu_ack, 0);

        // CPU read
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 14'h0123;
        tick();
        chk("rd_acc_grant", gvec(), 3'b001);
        chk("rd_acc_we", mem_we, 0);
        chk("rd_acc_addr", mem_addr, 14'h0123);
        tick();
        chk("rd_ack", cpu_ack, 1);
        chk("rd_data", cpu_rdata, 8'h5C);
        chk("rd_ack_we", mem_we, 0);
        cpu_req = 1'b0;
        tick();
        chk("rd_post_ack", cpu_ack, 0);
        chk("rd_hold", cpu_rdata, 8'h5C);

        // Render sweep, scanline 10, CPU write held high
        render_en = 1'b1;
        scanline  = 10'd10;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 14'h3F00;
        cpu_wdata = 8'h11;
        for (int x = 0; x <= 340; x++) begin
            x_idx    = 10'(x);
            bg_addr  = 16'h8400 + 16'(x);
            spr_addr = 16'h1800 + 16'(x);
            if (IDLE_EN && x >= 336) cpu_req = 1'b0;
            #1;
            if (x >= 256 && x <= 319) begin
                chk("sw_grant_spr", gvec(), 3'b010);
                chk("sw_addr_spr", mem_addr, 14'h1800 + 14'(x));
            end else begin
                chk("sw_grant_bg", gvec(), 3'b100);
                chk("sw_addr_bg", mem_addr, 14'h0400 + 14'(x));
            end
            chk("sw_we", mem_we, 0);
            chk("sw_ack", cpu_ack, 0);
            if (x <= 335) chk("sw_wait", cpu_wait, (x < 255) ? x : 255);
            tick();
        end
        chk("sw_wait_end", cpu_wait, IDLE_EN ? 0 : 255);
        cpu_req = 1'b0;
        tick();

        // Write accepted at 260/340, window closes before ACCESS
        render_en = 1'b0;
        scanline  = 10'd260;
        x_idx     = 10'd340;
        bg_addr   = 16'h8400;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 14'h2105;
        cpu_wdata = 8'h33;
        #1;
        chk("ab_idle_grant", gvec(), 3'b100);
        tick();
        render_en = 1'b1;
        scanline  = 10'd261;
        x_idx     = 10'd0;
        #1;
        chk("ab_acc_grant", gvec(), 3'b100);
        chk("ab_acc_we", mem_we, 0);
        chk("ab_acc_addr", mem_addr, 14'h0400);
        chk("ab_acc_ack", cpu_ack, 0);
        tick();
        x_idx = 10'd1;
        #1;
        chk("ab_noack", cpu_ack, 0);
        chk("ab_nocpu", gvec(), 3'b100);
        tick();
        render_en = 1'b0;
        x_idx     = 10'd2;
        tick();
        chk("ab_retry_grant", gvec(), 3'b001);
        chk("ab_retry_we", mem_we, 1);
        chk("ab_retry_addr", mem_addr, 14'h2105);
        chk("ab_retry_data", mem_wdata, 8'h33);
        tick();
        chk("ab_retry_ack", cpu_ack, 1);
        cpu_req = 1'b0;
        tick();

        // Idle-slot window at dots 336..338 on a render line
        render_en = 1'b1;
        scanline  = 10'd5;
        x_idx     = 10'd336;
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 14'h0123;
        #1;
        chk("is_336_grant", gvec(), 3'b100);
        tick();
        x_idx = 10'd337;
        #1;
        chk("is_337_grant", gvec(), IDLE_EN ? 3'b001 : 3'b100);
        chk("is_337_addr", mem_addr, IDLE_EN ? 14'h0123 : 14'h0400);
        tick();
        x_idx = 10'd338;
        #1;
        chk("is_338_ack", cpu_ack, IDLE_EN ? 1 : 0);
        if (IDLE_EN) chk("is_338_data", cpu_rdata, 8'h5C);
        cpu_req = 1'b0;
        tick();
        x_idx    = 10'd339;
        cpu_req  = 1'b1;
        cpu_addr = 14'h0044;
        #1;
        chk("is_339_ack", cpu_ack, 0);
        tick();
        x_idx = 10'd340;
        #1;
        chk("is_340_grant", gvec(), 3'b100);
        tick();
        scanline = 10'd6;
        x_idx    = 10'd0;
        #1;
        chk("is_next_ack", cpu_ack, 0);
        cpu_req = 1'b0;
        tick();

        // Reset during a write ACCESS
        render_en = 1'b0;
        scanline  = 10'd100;
        x_idx     = 10'd50;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 14'h0777;
        cpu_wdata = 8'h99;
        tick();
        chk("rs_acc_we", mem_we, 1);
        reset = 1'b1;
        #1;
        chk("rs_we", mem_we, 0);
        chk("rs_grant", gvec(), 3'b100);
        chk("rs_ack", cpu_ack, 0);
        cpu_req = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        chk("rs_post_ack", cpu_ack, 0);
        chk("rs_post_wait", cpu_wait, 0);
        chk("rs_post_rdata", cpu_rdata, 0);
        chk("rs_post_we", mem_we, 0);
        chk("rs_post_grant", gvec(), 3'b100);
        tick();
        chk("rs_noack", cpu_ack, 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
